// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder: op select + fields -> instruction word, with one registered
// valid/ready output stage, a byte-address counter and an illegal-request counter.
module rv_instr_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              restart,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err_illegal,
   output logic [7:0]        err_count
);

   typedef enum logic [2:0] {F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_BAD} fmt_e;

   fmt_e              fmt;
   logic [2:0]        f3;
   logic [6:0]        f7;
   logic [31:0]       instr;
   logic              legal;
   logic              i12_ok, b13_ok, j21_ok;
   logic              accept;
   logic [ADDR_W-1:0] next_addr;

   // Sign-extension checks: the bits above the field's sign bit must all match it.
   assign i12_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
   assign b13_ok = (&in_imm[31:12]) | ~(|in_imm[31:12]);
   assign j21_ok = (&in_imm[31:20]) | ~(|in_imm[31:20]);

   always_comb begin
      fmt = F_BAD;
      f3  = 3'b000;
      f7  = 7'h00;
      case (in_op)
         6'd1:  fmt = F_R;
         6'd2:  begin fmt = F_R;  f7 = 7'h20; end
         6'd3:  begin fmt = F_R;  f3 = 3'b001; end
         6'd4:  begin fmt = F_R;  f3 = 3'b010; end
         6'd5:  begin fmt = F_R;  f3 = 3'b011; end
         6'd6:  begin fmt = F_R;  f3 = 3'b100; end
         6'd7:  begin fmt = F_R;  f3 = 3'b101; end
         6'd8:  begin fmt = F_R;  f3 = 3'b101; f7 = 7'h20; end
         6'd9:  begin fmt = F_R;  f3 = 3'b110; end
         6'd10: begin fmt = F_R;  f3 = 3'b111; end
         6'd11: fmt = F_I;
         6'd12: begin fmt = F_SH; f3 = 3'b001; end
         6'd13: begin fmt = F_I;  f3 = 3'b010; end
         6'd14: begin fmt = F_I;  f3 = 3'b011; end
         6'd15: begin fmt = F_I;  f3 = 3'b100; end
         6'd16: begin fmt = F_SH; f3 = 3'b101; end
         6'd17: begin fmt = F_I;  f3 = 3'b110; end
         6'd18: begin fmt = F_I;  f3 = 3'b111; end
         6'd19: begin fmt = F_SH; f3 = 3'b101; f7 = 7'h20; end
         6'd27: fmt = F_B;
         6'd28: begin fmt = F_B;  f3 = 3'b001; end
         6'd31: begin fmt = F_B;  f3 = 3'b101; end
         6'd32: begin fmt = F_B;  f3 = 3'b100; end
         6'd33: fmt = F_U;
         6'd34: fmt = F_J;
         6'd35: begin fmt = F_I;  f3 = 3'b010; end
         6'd36: fmt = F_S;
         default: fmt = F_BAD;
      endcase
   end

   always_comb begin
      instr = '0;
      legal = 1'b1;
      case (fmt)
         F_R:  instr = {f7, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
         F_I:  begin
            // LW shares the I layout; only the major opcode differs.
            instr = {in_imm[11:0], in_rs1, f3, in_rd,
                     (in_op == 6'd35) ? 7'b0000011 : 7'b0010011};
            legal = i12_ok;
         end
         F_SH: begin
            instr = {f7, in_imm[4:0], in_rs1, f3, in_rd, 7'b0010011};
            legal = ~(|in_imm[31:5]);
         end
         F_S:  begin
            instr = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            legal = i12_ok;
         end
         F_B:  begin
            instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11],
                     7'b1100011};
            legal = b13_ok & ~in_imm[0];
         end
         F_U:  begin
            instr = {in_imm[31:12], in_rd, 7'b0110111};
            legal = ~(|in_imm[11:0]);
         end
         F_J:  begin
            instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
            legal = j21_ok & ~in_imm[0];
         end
         default: legal = 1'b0;
      endcase
   end

   assign in_ready = !restart && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         out_instr   <= '0;
         out_addr    <= BASE_ADDR;
         next_addr   <= BASE_ADDR;
         err_illegal <= 1'b0;
         err_count   <= '0;
      end else if (restart) begin
         out_valid   <= 1'b0;
         next_addr   <= BASE_ADDR;
         err_illegal <= 1'b0;
      end else begin
         err_illegal <= accept && !legal;
         if (accept && legal) begin
            out_valid <= 1'b1;
            out_instr <= instr;
            out_addr  <= next_addr;
            next_addr <= next_addr + ADDR_W'(4);
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept && !legal && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed bench for rv_instr_encoder: encoding table plus handshake, wrap, restart and reset sequences.
module tb_rv_instr_encoder;

   logic        clk = 1'b0;
   logic        reset, restart, in_valid, out_ready;
   logic [5:0]  in_op;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm;
   logic        in_ready, out_valid, err_illegal;
   logic [31:0] out_instr, out_addr;
   logic [7:0]  err_count;
   logic        in_ready4, out_valid4, err_illegal4;
   logic [31:0] out_instr4;
   logic [3:0]  out_addr4;
   logic [7:0]  err_count4;

   always #5 clk = ~clk;

   rv_instr_encoder dut (
      .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
      .err_illegal(err_illegal), .err_count(err_count));

   // Narrow-address copy driven by the same stimulus, used for the wrap check.
   rv_instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'h0)) dut4 (
      .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_ready(in_ready4),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid4), .out_ready(out_ready), .out_instr(out_instr4), .out_addr(out_addr4),
      .err_illegal(err_illegal4), .err_count(err_count4));

   typedef struct {
      logic [5:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic        legal;
      logic [31:0] instr;
   } vec_t;

   vec_t vecs[$];
   int   npass = 0, ntot = 0;
   int   ecnt = 0;
   logic [31:0] ea;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
      in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
   endtask

   initial begin
      reset = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;

      //             op   rd  rs1 rs2  imm            legal instr
      vecs.push_back('{6'd1,  5'd3, 5'd1, 5'd2, 32'd0,        1'b1, 32'h002081B3}); // ADD
      vecs.push_back('{6'd11, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00293}); // ADDI -1
      vecs.push_back('{6'd36, 5'd9, 5'd1, 5'd2, 32'd8,        1'b1, 32'h0020A423}); // SW, rd ignored
      vecs.push_back('{6'd27, 5'd7, 5'd1, 5'd2, -32'sd4,      1'b1, 32'hFE208EE3}); // BEQ -4
      vecs.push_back('{6'd27, 5'd0, 5'd1, 5'd2, -32'sd3,      1'b0, 32'h0});        // BEQ odd
      vecs.push_back('{6'd27, 5'd0, 5'd1, 5'd2, 32'd4096,     1'b0, 32'h0});        // BEQ range
      vecs.push_back('{6'd2,  5'd3, 5'd1, 5'd2, 32'd0,        1'b1, 32'h402081B3}); // SUB
      vecs.push_back('{6'd19, 5'd5, 5'd6, 5'd0, 32'd3,        1'b1, 32'h40335293}); // SRAI 3
      vecs.push_back('{6'd12, 5'd5, 5'd6, 5'd0, 32'd32,       1'b0, 32'h0});        // SLLI 32
      vecs.push_back('{6'd33, 5'd7, 5'd3, 5'd0, 32'h12345000, 1'b1, 32'h123453B7}); // LUI
      vecs.push_back('{6'd33, 5'd7, 5'd0, 5'd0, 32'h12345001, 1'b0, 32'h0});        // LUI low bits
      vecs.push_back('{6'd34, 5'd1, 5'd0, 5'd0, 32'd8,        1'b1, 32'h008000EF}); // JAL 8
      vecs.push_back('{6'd34, 5'd0, 5'd0, 5'd0, -32'sd2,      1'b1, 32'hFFFFF06F}); // JAL -2
      vecs.push_back('{6'd34, 5'd1, 5'd0, 5'd0, 32'd1,        1'b0, 32'h0});        // JAL odd
      vecs.push_back('{6'd0,  5'd1, 5'd1, 5'd1, 32'd0,        1'b0, 32'h0});        // op 0
      vecs.push_back('{6'd20, 5'd1, 5'd1, 5'd1, 32'd0,        1'b0, 32'h0});        // gap op
      vecs.push_back('{6'd11, 5'd1, 5'd0, 5'd0, 32'd2048,     1'b0, 32'h0});        // ADDI 2048
      vecs.push_back('{6'd11, 5'd1, 5'd0, 5'd0, -32'sd2048,   1'b1, 32'h80000093}); // ADDI -2048
      vecs.push_back('{6'd35, 5'd5, 5'd2, 5'd0, 32'd4,        1'b1, 32'h00412283}); // LW
      vecs.push_back('{6'd31, 5'd0, 5'd3, 5'd4, 32'd16,       1'b1, 32'h0041D863}); // BGE 16
      vecs.push_back('{6'd10, 5'd10,5'd11,5'd12,32'd0,        1'b1, 32'h00C5F533}); // AND
      vecs.push_back('{6'd36, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFF, 1'b1, 32'hFE20AFA3}); // SW -1
      vecs.push_back('{6'd28, 5'd0, 5'd0, 5'd0, 32'd4094,     1'b1, 32'h7E001FE3}); // BNE max
      vecs.push_back('{6'd32, 5'd0, 5'd0, 5'd0, -32'sd4096,   1'b1, 32'h80004063}); // BLT min

      step(); step();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_addr", out_addr, 32'd0);
      chk("rst_err_illegal", {31'd0, err_illegal}, 32'd0);
      chk("rst_err_count", {24'd0, err_count}, 32'd0);
      reset = 1'b0;
      #1;
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

      // Table: back-to-back requests with the sink always ready.
      ea = 32'd0;
      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
         step();
         if (!vecs[i].legal && ecnt < 255) ecnt++;
         chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].legal});
         chk($sformatf("v%0d_err", i), {31'd0, err_illegal}, {31'd0, !vecs[i].legal});
         chk($sformatf("v%0d_count", i), {24'd0, err_count}, ecnt);
         if (vecs[i].legal) begin
            chk($sformatf("v%0d_instr", i), out_instr, vecs[i].instr);
            chk($sformatf("v%0d_addr", i), out_addr, ea);
            ea += 32'd4;
         end
      end
      in_valid = 1'b0;
      step();
      chk("drain_valid", {31'd0, out_valid}, 32'd0);
      chk("drain_err", {31'd0, err_illegal}, 32'd0);

      // Back-to-back from a fresh restart.
      restart = 1'b1; step(); restart = 1'b0;
      drive(6'd11, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF); step();
      chk("b2b_instr0", out_instr, 32'hFFF00293);
      chk("b2b_addr0", out_addr, 32'h0);
      drive(6'd36, 5'd0, 5'd1, 5'd2, 32'd8); step();
      chk("b2b_instr1", out_instr, 32'h0020A423);
      chk("b2b_addr1", out_addr, 32'h4);
      in_valid = 1'b0; step();

      // Backpressure: second request held off for three cycles.
      restart = 1'b1; step(); restart = 1'b0;
      drive(6'd1, 5'd3, 5'd1, 5'd2, 32'd0); step();
      chk("bp_first_addr", out_addr, 32'h0);
      out_ready = 1'b0;
      drive(6'd35, 5'd5, 5'd2, 5'd0, 32'd4);
      #1;
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
         chk($sformatf("bp%0d_instr", k), out_instr, 32'h002081B3);
         chk($sformatf("bp%0d_addr", k), out_addr, 32'h0);
         chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("bp_second_instr", out_instr, 32'h00412283);
      chk("bp_second_addr", out_addr, 32'h4);
      in_valid = 1'b0; step();
      chk("bp_drained", {31'd0, out_valid}, 32'd0);

      // 4-bit address wrap and non-advancing illegal requests.
      restart = 1'b1; step(); restart = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive(6'd1, 5'd3, 5'd1, 5'd2, 32'd0); step();
         chk($sformatf("wrap%0d_addr", k), {28'd0, out_addr4}, (k * 4) % 16);
      end
      drive(6'd0, 5'd0, 5'd0, 5'd0, 32'd0); step();
      if (ecnt < 255) ecnt++;
      chk("wrap_ill0_valid", {31'd0, out_valid4}, 32'd0);
      chk("wrap_ill0_err", {31'd0, err_illegal}, 32'd1);
      drive(6'd11, 5'd1, 5'd0, 5'd0, 32'd2048); step();
      if (ecnt < 255) ecnt++;
      chk("wrap_ill1_valid", {31'd0, out_valid4}, 32'd0);
      chk("wrap_ill_count", {24'd0, err_count}, ecnt);
      drive(6'd1, 5'd3, 5'd1, 5'd2, 32'd0); step();
      chk("wrap_after_ill_addr", {28'd0, out_addr4}, 32'h4);

      // Restart while stalled with a request pending.
      out_ready = 1'b0;
      drive(6'd1, 5'd3, 5'd1, 5'd2, 32'd0);
      restart = 1'b1;
      #1;
      chk("rs_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("rs_out_valid", {31'd0, out_valid}, 32'd0);
      restart = 1'b0; out_ready = 1'b1;
      drive(6'd1, 5'd3, 5'd1, 5'd2, 32'd0); step();
      chk("rs_next_addr", out_addr, 32'h0);
      chk("rs_next_valid", {31'd0, out_valid}, 32'd1);
      chk("rs_count_kept", {24'd0, err_count}, ecnt);

      // Saturation of the illegal counter.
      drive(6'd63, 5'd0, 5'd0, 5'd0, 32'd0);
      for (int k = 0; k < 260; k++) begin
         step();
         if (ecnt < 255) ecnt++;
      end
      in_valid = 1'b0; step();
      chk("sat_count", {24'd0, err_count}, ecnt);
      chk("sat_count_255", {24'd0, err_count}, 32'd255);

      // Reset mid-stall discards everything.
      drive(6'd1, 5'd3, 5'd1, 5'd2, 32'd0); step();
      out_ready = 1'b0; in_valid = 1'b0;
      reset = 1'b1; step();
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_instr", out_instr, 32'd0);
      chk("mid_rst_addr", out_addr, 32'd0);
      chk("mid_rst_err", {31'd0, err_illegal}, 32'd0);
      chk("mid_rst_count", {24'd0, err_count}, 32'd0);
      reset = 1'b0; out_ready = 1'b1;
      drive(6'd11, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF); step();
      chk("post_rst_addr", out_addr, 32'h0);
      chk("post_rst_instr", out_instr, 32'hFFF00293);
      in_valid = 1'b0; step();

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
